player_motion: RTL and testbench

- Per-frame player kinematics and scroll controller.
- Sits directly upstream of the background tile lookup stage: it produces playerX, playerY and progress, and that stage consumes them.
- Consumes that stage's combinational ground-height result p_Y_max to decide landing and falling.
- Outputs are registered and change only once per video frame.

---
 rtl/contra_pkg.sv | 17 +
 rtl/player_motion_if.sv | 27 ++
 rtl/frame_tick_gen.sv | 18 +
 rtl/player_motion.sv | 122 ++++++++++++
 tb/tb_player_motion.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/contra_pkg.sv
// Shared types and screen/level geometry for the player and tile stages.
package contra_pkg;

  typedef enum logic [1:0] {
    GROUND,
    JUMP,
    FALL,
    DEAD
  } player_state_t;

  localparam int TILE_SIZE = 96;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int LEVEL_W   = 3840;
  localparam int NO_FLOOR  = 540;

endpackage

// File: rtl/player_motion_if.sv
// Key inputs, ground height and registered kinematics outputs.
interface player_motion_if;
  import contra_pkg::*;

  logic       left;
  logic       right;
  logic       jump;
  logic [9:0] p_Y_max;
  logic [9:0] playerX;
  logic [9:0] playerY;
  logic [11:0] progress;
  logic       on_ground;
  logic       dead;

  modport master (
    output left, right, jump, p_Y_max,
    input  playerX, playerY, progress,
    input  on_ground, dead
  );

  modport slave (
    input  left, right, jump, p_Y_max,
    output playerX, playerY, progress,
    output on_ground, dead
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Synchronizes the vsync-rate level and emits a one-cycle rising-edge pulse.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic [2:0] sync;

  always_ff @(posedge Clk) begin
    if (Reset) sync <= '0;
    else       sync <= {sync[1:0], frame_clk};
  end

  assign tick = sync[1] & ~sync[2];

endmodule

// File: rtl/player_motion.sv
// Per-frame player kinematics: vertical FSM, horizontal move and scroll.
module player_motion
  import contra_pkg::*;
#(
  parameter int X_START  = 64,
  parameter int X_SCROLL = 320,
  parameter int X_MAX    = 608,
  parameter int PROG_MAX = 3200,
  parameter int H_SPEED  = 2,
  parameter int JUMP_V   = 12,
  parameter int V_MAX    = 8,
  parameter int Y_DEAD   = 480
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  player_motion_if.slave bus
);

  localparam logic signed [10:0] YD = 11'(Y_DEAD);
  localparam logic signed [5:0]  VM = 6'(V_MAX);
  localparam logic signed [5:0]  JV = 6'(JUMP_V);

  logic tick;

  player_state_t     state, state_n;
  logic signed [5:0] vy, vy_n, vy_inc, vy_fall;
  logic [9:0]        x, x_n, y, y_n;
  logic [11:0]       prog, prog_n;
  logic signed [10:0] next_y, py;

  frame_tick_gen u_tick (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .tick     (tick)
  );

  assign next_y  = $signed({1'b0, y}) + {{5{vy[5]}}, vy};
  assign py      = $signed({1'b0, bus.p_Y_max});
  assign vy_inc  = vy + 6'sd1;
  assign vy_fall = (vy >= VM) ? VM : vy_inc;

  always_comb begin
    state_n = state;
    vy_n    = vy;
    y_n     = y;
    x_n     = x;
    prog_n  = prog;

    unique case (state)
      GROUND: begin
        if (bus.jump) begin
          vy_n    = -JV;
          state_n = JUMP;
        end else if (bus.p_Y_max > y) begin
          vy_n    = '0;
          state_n = FALL;
        end
      end
      JUMP: begin
        y_n  = next_y[10] ? '0 : next_y[9:0];
        vy_n = vy_inc;
        if (!vy_inc[5]) state_n = FALL;
      end
      FALL: begin
        vy_n = vy_fall;
        if (next_y >= py && bus.p_Y_max < 10'(Y_DEAD)) begin
          y_n     = bus.p_Y_max;
          vy_n    = '0;
          state_n = GROUND;
        end else if (next_y >= YD) begin
          y_n     = 10'(Y_DEAD);
          state_n = DEAD;
        end else begin
          y_n = next_y[9:0];
        end
      end
      DEAD: ;
    endcase

    // Scroll takes priority over moving right once the player is mid-screen.
    if (state != DEAD) begin
      unique case (1'b1)
        (bus.right & ~bus.left): begin
          if (x >= 10'(X_SCROLL) && prog < 12'(PROG_MAX))
            prog_n = (prog >= 12'(PROG_MAX - H_SPEED)) ?
                     12'(PROG_MAX) : prog + 12'(H_SPEED);
          else
            x_n = (x >= 10'(X_MAX - H_SPEED)) ?
                  10'(X_MAX) : x + 10'(H_SPEED);
        end
        (bus.left & ~bus.right):
          x_n = (x < 10'(H_SPEED)) ? '0 : x - 10'(H_SPEED);
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FALL;
      vy    <= '0;
      x     <= 10'(X_START);
      y     <= '0;
      prog  <= '0;
    end else if (tick) begin
      state <= state_n;
      vy    <= vy_n;
      x     <= x_n;
      y     <= y_n;
      prog  <= prog_n;
    end
  end

  assign bus.playerX   = x;
  assign bus.playerY   = y;
  assign bus.progress  = prog;
  assign bus.on_ground = (state == GROUND);
  assign bus.dead      = (state == DEAD);

endmodule

// File: tb/tb_player_motion.sv
// Randomized and directed bench for player_motion against a per-frame model.
module tb_player_motion;

  localparam int G = 0, J = 1, F = 2, D = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic frame_clk = 1'b0;

  player_motion_if bus ();

  player_motion dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .bus      (bus)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int mx, my, mp, mvy, ms;

  task automatic check(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mx = 64; my = 0; mp = 0; mvy = 0; ms = F;
  endfunction

  function automatic void model_step();
    int l = int'(bus.left);
    int r = int'(bus.right);
    int jmp = int'(bus.jump);
    int p = int'(bus.p_Y_max);
    int ny, vn;
    if (ms == D) return;
    if (r == 1 && l == 0) begin
      if (mx >= 320 && mp < 3200) mp = (mp + 2 > 3200) ? 3200 : mp + 2;
      else mx = (mx + 2 > 608) ? 608 : mx + 2;
    end else if (l == 1 && r == 0) begin
      mx = (mx - 2 < 0) ? 0 : mx - 2;
    end
    ny = my + mvy;
    case (ms)
      G: begin
        if (jmp == 1) begin mvy = -12; ms = J; end
        else if (p > my) begin mvy = 0; ms = F; end
      end
      J: begin
        my = (ny < 0) ? 0 : ny;
        mvy = mvy + 1;
        if (mvy >= 0) ms = F;
      end
      F: begin
        vn = (mvy + 1 > 8) ? 8 : mvy + 1;
        if (ny >= p && p < 480) begin my = p; mvy = 0; ms = G; end
        else if (ny >= 480) begin my = 480; mvy = vn; ms = D; end
        else begin my = ny; mvy = vn; end
      end
      default: ;
    endcase
  endfunction

  always @(negedge Clk) begin
    if (chk_en) begin
      check("playerX", int'(bus.playerX), mx);
      check("playerY", int'(bus.playerY), my);
      check("progress", int'(bus.progress), mp);
      check("on_ground", int'(bus.on_ground), int'(ms == G));
      check("dead", int'(bus.dead), int'(ms == D));
    end
  end

  task automatic keys(bit l, bit r, bit jmp);
    bus.left = l; bus.right = r; bus.jump = jmp;
  endtask

  task automatic tick(int hold = 4);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    model_step();
    repeat (hold) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(posedge Clk);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int k;
    int pys [6] = '{96, 192, 288, 384, 480, 540};
    keys(0, 0, 0);
    bus.p_Y_max = 10'd288;
    model_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    do_reset();
    chk_en = 1'b1;
    check("rst_x", int'(bus.playerX), 64);
    check("rst_y", int'(bus.playerY), 0);
    check("rst_prog", int'(bus.progress), 0);
    check("rst_dead", int'(bus.dead), 0);

    ticks(9);
    check("fall_y9", int'(bus.playerY), 36);
    ticks(32);
    check("land_y41", int'(bus.playerY), 288);
    check("land_ground", int'(bus.on_ground), 1);

    keys(0, 0, 1);
    tick();
    keys(0, 0, 0);
    check("jump_start_y", int'(bus.playerY), 288);
    check("jump_left_ground", int'(bus.on_ground), 0);
    ticks(12);
    check("jump_apex_y", int'(bus.playerY), 210);
    k = 0;
    while (ms != G && k < 40) begin tick(); k++; end
    check("relanded", int'(bus.on_ground), 1);
    check("reland_y", int'(bus.playerY), 288);

    keys(0, 1, 0);
    ticks(128);
    check("reach_scroll_x", int'(bus.playerX), 320);
    ticks(10);
    check("scroll_prog20", int'(bus.progress), 20);
    check("scroll_x_held", int'(bus.playerX), 320);
    ticks(1590);
    check("prog_max", int'(bus.progress), 3200);
    tick();
    check("walk_past_scroll", int'(bus.playerX), 322);
    ticks(150);
    check("x_max_clamp", int'(bus.playerX), 608);

    keys(1, 1, 0);
    ticks(5);
    check("both_keys_x", int'(bus.playerX), 608);
    check("both_keys_prog", int'(bus.progress), 3200);

    keys(1, 0, 0);
    ticks(306);
    check("left_clamp0", int'(bus.playerX), 0);
    check("left_prog_kept", int'(bus.progress), 3200);

    keys(0, 1, 0);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    model_step();
    repeat (100) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    check("long_level_one_step", int'(bus.playerX), 2);

    @(negedge Clk);
    frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(posedge Clk);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    check("reset_beats_tick_x", int'(bus.playerX), 64);

    keys(0, 0, 0);
    bus.p_Y_max = 10'd540;
    k = 0;
    while (ms != D && k < 100) begin tick(); k++; end
    check("died", int'(bus.dead), 1);
    check("dead_y", int'(bus.playerY), 480);
    for (int i = 0; i < 10; i++) begin
      keys(1'($urandom), 1'($urandom), 1'($urandom));
      bus.p_Y_max = 10'(pys[$urandom_range(0, 5)]);
      tick();
    end
    check("dead_frozen_y", int'(bus.playerY), 480);
    do_reset();
    check("revive_x", int'(bus.playerX), 64);
    check("revive_y", int'(bus.playerY), 0);
    check("revive_dead", int'(bus.dead), 0);

    for (int i = 0; i < 500; i++) begin
      keys(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 0)
        bus.p_Y_max = 10'(pys[$urandom_range(0, 5)]);
      else
        bus.p_Y_max = 10'($urandom_range(0, 539));
      tick($urandom_range(2, 10));
      if ((ms == D && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0)
        do_reset();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
